// File: rtl/data_memory_responder.sv
// data_memory_responder: responder end of the load/store-unit data memory port.
// Word-organised RAM with per-byte write lanes and a fixed number of wait
// states between accepting a request and answering it with a one-cycle
// ready pulse. Full 32-bit words are returned; the LSU handles sub-word
// extraction.
//
// Build option: define MEM_ALIGN_CHECK_EN to flag writes whose byte map is
// not a naturally aligned byte/half/word access as errors (no array update).
//
// state | meaning
// IDLE  | waiting for memory_require, request fields follow the inputs
// WAIT  | request latched, wait-state counter running down
// RESP  | access done on the entering edge, ready (and error) pulsed
module data_memory_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2,
   parameter     INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memory_require,
   input  logic        memory_write_enable,
   input  logic [3:0]  memory_bytes_enable_map,
   input  logic [31:0] memory_address,
   input  logic [31:0] memory_write_data,
   output logic [31:0] memory_read_data,
   output logic        memory_ready,
   output logic        memory_error,
   output logic        busy
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             lat_we_q;
   logic [3:0]       lat_map_q;
   logic [31:0]      lat_addr_q;
   logic [31:0]      lat_wdata_q;
   logic [31:0]      read_data_q;
   logic             error_q;

   logic [31:0]      mem_q [0:(1<<ADDR_WIDTH)-1];

   logic                  cur_we;
   logic [3:0]            cur_map;
   logic [31:0]           cur_addr;
   logic [31:0]           cur_wdata;
   logic [ADDR_WIDTH-1:0] cur_idx;
   logic                  cur_oor;
   logic                  cur_align_bad;
   logic                  cur_err;
   logic                  access_go;
   logic                  do_write;

   // With zero wait states the access happens on the acceptance edge itself,
   // so the request fields come straight from the inputs while idle.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_we    = memory_write_enable;
         cur_map   = memory_bytes_enable_map;
         cur_addr  = memory_address;
         cur_wdata = memory_write_data;
      end else begin
         cur_we    = lat_we_q;
         cur_map   = lat_map_q;
         cur_addr  = lat_addr_q;
         cur_wdata = lat_wdata_q;
      end
   end

   assign cur_idx = cur_addr[ADDR_WIDTH+1:2];
   assign cur_oor = (cur_addr[31:ADDR_WIDTH+2] != '0);

`ifdef MEM_ALIGN_CHECK_EN
   // Only single bytes, aligned halves and aligned words are legal writes.
   always_comb begin
      cur_align_bad = 1'b1;
      case (cur_map)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: cur_align_bad = 1'b0;
         4'b0011:                            cur_align_bad = (cur_addr[1:0] != 2'b00);
         4'b1100:                            cur_align_bad = (cur_addr[1:0] != 2'b10);
         4'b1111:                            cur_align_bad = (cur_addr[1:0] != 2'b00);
         default:                            cur_align_bad = 1'b1;
      endcase
   end
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^cur_addr[1:0];
   assign cur_align_bad   = 1'b0;
`endif

   assign cur_err   = cur_oor | (cur_we & cur_align_bad);
   assign access_go = ((state_q == ST_IDLE) && memory_require && (WAIT_CYCLES == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == '0));
   assign do_write  = access_go & cur_we & ~cur_err;

   // State and wait counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (memory_require) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs derived from the current state.
   always_comb begin
      memory_ready = (state_q == ST_RESP);
      memory_error = (state_q == ST_RESP) & error_q;
      busy         = (state_q != ST_IDLE);
   end

   assign memory_read_data = read_data_q;

   // Request capture on acceptance; later input changes are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_we_q    <= 1'b0;
         lat_map_q   <= '0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
      end else if ((state_q == ST_IDLE) && memory_require) begin
         lat_we_q    <= memory_write_enable;
         lat_map_q   <= memory_bytes_enable_map;
         lat_addr_q  <= memory_address;
         lat_wdata_q <= memory_write_data;
      end
   end

   // Read word and error flag are captured on the edge entering RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_data_q <= '0;
         error_q     <= 1'b0;
      end else if (access_go) begin
         error_q <= cur_err;
         if (!cur_we) read_data_q <= cur_oor ? 32'h0000_0000 : mem_q[cur_idx];
      end
   end

   // Lane-masked array write; gated by reset so an aborted request never lands.
   always_ff @(posedge clk) begin
      if (do_write && reset) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_map[i]) mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a wait-state-2 instance and a
// zero-wait-state instance, each tracked by a transaction-level model.
module tb_data_memory_responder;

   localparam int AW = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req   [2];
   logic        we    [2];
   logic [3:0]  map   [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        rdy   [2];
   logic        err   [2];
   logic        bsy   [2];

   typedef struct {
      int          acc;
      int          resp;
      logic        w;
      logic [3:0]  m;
      logic [31:0] a;
      logic [31:0] dat;
   } txn_t;

   txn_t        mq [2][$];
   logic [31:0] ref_mem [2][16];
   logic [31:0] m_rd [2];
   int          last_resp [2];
   int          rp1 [$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .reset(rst_n),
      .memory_require(req[0]), .memory_write_enable(we[0]),
      .memory_bytes_enable_map(map[0]), .memory_address(addr[0]),
      .memory_write_data(wdata[0]), .memory_read_data(rdata[0]),
      .memory_ready(rdy[0]), .memory_error(err[0]), .busy(bsy[0])
   );

   data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(rst_n),
      .memory_require(req[1]), .memory_write_enable(we[1]),
      .memory_bytes_enable_map(map[1]), .memory_address(addr[1]),
      .memory_write_data(wdata[1]), .memory_read_data(rdata[1]),
      .memory_ready(rdy[1]), .memory_error(err[1]), .busy(bsy[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int wc(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic void chk(input string name, input int d,
                               input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, d, cyc, act, exp);
   endfunction

   function automatic bit align_ok(input logic [3:0] m, input logic [1:0] a);
      return (m == 4'd1) || (m == 4'd2) || (m == 4'd4) || (m == 4'd8) ||
             (m == 4'd3 && a == 2'd0) || (m == 4'd12 && a == 2'd2) ||
             (m == 4'd15 && a == 2'd0);
   endfunction

   // Applies one transaction to the reference memory; returns its error flag.
   function automatic bit model_resp(input int d, input txn_t t);
      bit         oor;
      bit         bad;
      logic [3:0] idx;
      oor = (t.a[31:AW+2] != '0);
      bad = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      bad = t.w && !align_ok(t.m, t.a[1:0]);
`endif
      idx = t.a[5:2];
      if (!t.w) begin
         m_rd[d] = oor ? 32'h0 : ref_mem[d][idx];
      end else if (!(oor || bad)) begin
         for (int i = 0; i < 4; i++)
            if (t.m[i]) ref_mem[d][idx][8*i +: 8] = t.dat[8*i +: 8];
      end
      return oor || bad;
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic eb, er, ee;
      txn_t t;
      for (int d = 0; d < 2; d++) begin
         eb = 1'b0; er = 1'b0; ee = 1'b0;
         if (!rst_n) begin
            mq[d].delete();
            m_rd[d] = 32'h0;
         end else if (mq[d].size() > 0) begin
            t  = mq[d][0];
            eb = (t.acc <= cyc);
            if (t.resp == cyc) begin
               er = 1'b1;
               ee = model_resp(d, t);
               void'(mq[d].pop_front());
            end
         end
         chk("busy",  d, 32'(bsy[d]), 32'(eb));
         chk("ready", d, 32'(rdy[d]), 32'(er));
         chk("error", d, 32'(err[d]), 32'(ee));
         chk("rdata", d, rdata[d], m_rd[d]);
         if (d == 1 && rdy[1] === 1'b1) rp1.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic scramble(input int d);
      logic [31:0] r;
      r = $urandom;
      we[d]    = r[0];
      map[d]   = r[7:4];
      addr[d]  = $urandom;
      wdata[d] = $urandom;
   endtask

   // Issues one request, holds it until the response cycle, scrambling the
   // inputs while the responder should be working from its latched copy.
   task automatic access(input int d, input logic w, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] dat);
      txn_t t;
      t.acc  = (cyc + 1 > last_resp[d] + 2) ? cyc + 1 : last_resp[d] + 2;
      t.resp = t.acc + wc(d);
      t.w = w; t.m = m; t.a = a; t.dat = dat;
      req[d] = 1'b1; we[d] = w; map[d] = m; addr[d] = a; wdata[d] = dat;
      mq[d].push_back(t);
      last_resp[d] = t.resp;
      while (cyc < t.acc) tick();
      while (cyc < t.resp) begin
         scramble(d);
         tick();
      end
      req[d] = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] r;
      r = $urandom;
      if (r[31:28] == 4'hF) return {r[19:0] | 20'h1, r[11:0]};
      return {26'h0, r[5:0]};
   endfunction

   initial begin
      int k;
      txn_t t;
      logic [31:0] r;
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; map[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
         last_resp[d] = -10;
         m_rd[d] = 32'h0;
      end
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++) access(d, 1'b1, 4'hF, 32'(i * 4), $urandom);

      // Word write/read with fixed latency on the two-wait-state instance.
      tick(); tick();
      k = cyc;
      access(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
      chk("lat_w2", 0, 32'(cyc - k), 32'd3);
      chk("wr_rdy", 0, 32'(rdy[0]), 32'd1);
      chk("wr_err", 0, 32'(err[0]), 32'd0);
      access(0, 1'b0, 4'hF, 32'h10, 32'h0);
      chk("rd_word", 0, rdata[0], 32'hDEAD_BEEF);
      access(0, 1'b1, 4'b0100, 32'h10, 32'hAAAA_AAAA);
      access(0, 1'b0, 4'hF, 32'h10, 32'h0);
      chk("rd_byte", 0, rdata[0], 32'hDEAA_BEEF);
      access(0, 1'b1, 4'b0011, 32'h10, 32'h1234_1234);
      access(0, 1'b0, 4'hF, 32'h10, 32'h0);
      chk("rd_half", 0, rdata[0], 32'hDEAA_1234);
      access(0, 1'b1, 4'hF, 32'h30, 32'hCAFE_F00D);
      access(0, 1'b0, 4'hF, 32'h30, 32'h0);
      chk("rd_latched", 0, rdata[0], 32'hCAFE_F00D);

      // Back-to-back requests on the zero-wait-state instance.
      tick(); tick();
      rp1.delete();
      k = cyc;
      access(1, 1'b1, 4'hF, 32'h4, 32'h1111_1111);
      chk("lat_w0", 1, 32'(cyc - k), 32'd1);
      access(1, 1'b1, 4'hF, 32'h8, 32'h2222_2222);
      access(1, 1'b0, 4'hF, 32'h4, 32'h0);
      chk("b2b_rd1", 1, rdata[1], 32'h1111_1111);
      access(1, 1'b0, 4'hF, 32'h8, 32'h0);
      chk("b2b_rd2", 1, rdata[1], 32'h2222_2222);
      tick();
      chk("b2b_cnt", 1, 32'(rp1.size()), 32'd4);
      for (int i = 1; i < rp1.size(); i++) chk("b2b_gap", 1, 32'(rp1[i] - rp1[i-1]), 32'd2);

      // Out-of-range accesses.
      access(0, 1'b1, 4'hF, 32'h0, 32'h0102_0304);
      access(0, 1'b0, 4'hF, 32'h1000, 32'h0);
      chk("oor_rd", 0, rdata[0], 32'h0);
      chk("oor_rdy", 0, 32'(rdy[0]), 32'd1);
      chk("oor_err", 0, 32'(err[0]), 32'd1);
      access(0, 1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF);
      chk("oor_wr_err", 0, 32'(err[0]), 32'd1);
      access(0, 1'b0, 4'hF, 32'h0, 32'h0);
      chk("oor_keep", 0, rdata[0], 32'h0102_0304);

      // Reset in the middle of a write's wait states.
      access(0, 1'b1, 4'hF, 32'h20, 32'h0BAD_F00D);
      tick(); tick();
      t.acc = cyc + 1; t.resp = t.acc + 2;
      t.w = 1'b1; t.m = 4'hF; t.a = 32'h20; t.dat = 32'h5555_5555;
      req[0] = 1'b1; we[0] = 1'b1; map[0] = 4'hF; addr[0] = 32'h20; wdata[0] = 32'h5555_5555;
      mq[0].push_back(t);
      while (cyc < t.acc) tick();
      tick();
      rst_n = 1'b0;
      req[0] = 1'b0;
      #1;
      chk("rst_rdy", 0, 32'(rdy[0]), 32'd0);
      chk("rst_rdata", 0, rdata[0], 32'h0);
      chk("rst_busy", 0, 32'(bsy[0]), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      last_resp[0] = -10;
      last_resp[1] = -10;
      tick();
      access(0, 1'b0, 4'hF, 32'h20, 32'h0);
      chk("rst_keep", 0, rdata[0], 32'h0BAD_F00D);

      // Half-word writes against address alignment.
      access(0, 1'b1, 4'b0011, 32'h22, 32'h7777_7777);
`ifdef MEM_ALIGN_CHECK_EN
      chk("align_bad_err", 0, 32'(err[0]), 32'd1);
`else
      chk("align_bad_err", 0, 32'(err[0]), 32'd0);
`endif
      access(0, 1'b1, 4'b1100, 32'h22, 32'h9999_9999);
      chk("align_ok_err", 0, 32'(err[0]), 32'd0);
      access(0, 1'b0, 4'hF, 32'h20, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
      chk("align_word", 0, rdata[0], 32'h9999_F00D);
`else
      chk("align_word", 0, rdata[0], 32'h9999_7777);
`endif

      // Random traffic on both instances.
      repeat (300) begin
         r = $urandom;
         access(int'(r[0]), r[1], r[7:4], rand_addr(), $urandom);
         if (r[11:9] == 3'd0) tick();
      end

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
